rangebin_addr_gen: RTL
======================

# rangebin_addr_gen

Parametrised range-bin address generator for the spectrum-accumulation path. It produces a read-side bin index that advances on each completed bin calculation, and a write-side bin index that advances the same way but delayed by the accumulator pipeline latency, so read and write addresses of the accumulation RAM stay aligned. Bin count, address width, pipeline lead and end-of-range mode (wrap or saturate) are generics. The block also flags frame completion and overrun. It sits between the FFT/power calculation stage and the accumulation RAM, and is cleared by the accumulation-done strobe.

## Interface
- BIN_W, 5, width of bin indices
- NUM_BINS, 32, number of range bins per frame; 2 ≤ NUM_BINS ≤ 2^BIN_W
- RD_LEAD, 3, cycles by which the write index lags the read index; 1..15
- SATURATE, 0, 0 = indices wrap to 0 after the last bin; 1 = indices stop at the last bin and further pulses are rejected

- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cal_done  in  1  single-cycle pulse, one bin calculation completed
- SPEC_Acc_Done  in  1  single-cycle pulse, accumulation finished; clears the block
- bin_counts_rd  out  BIN_W  read-side bin index (RAM read address)
- bin_counts  out  BIN_W  write-side bin index (RAM write address)
- rd_last  out  1  high while bin_counts_rd == NUM_BINS-1
- frame_done  out  1  one-cycle pulse when the write side completes bin NUM_BINS-1
- overflow  out  1  sticky; a cal_done was rejected in saturate mode

## Operation
- Accepted pulse: acc = cal_done & ~rd_full. rd_full exists only when SATURATE=1 and is otherwise constant 0.
- Read counter:
  - On acc with bin_counts_rd < NUM_BINS-1: increment.
  - On acc with bin_counts_rd == NUM_BINS-1:
    - SATURATE=0: load 0.
    - SATURATE=1: hold the value and set rd_full.
- Rejected pulse (cal_done & rd_full): read counter unchanged; overflow set; the pulse is not forwarded to the write side.
- Delay line: acc passes through an RD_LEAD-stage shift register; its output is wr_acc.
- Write counter: on wr_acc, same increment / wrap / hold rule as the read counter, applied to bin_counts. A wr_full flag is kept for SATURATE=1.
- frame_done: pulses on the edge where wr_acc occurs while bin_counts == NUM_BINS-1. In saturate mode it fires once per frame.
- Clear: SPEC_Acc_Done or rst zeroes both counters, rd_full, wr_full, all delay stages, frame_done and overflow.
  - Clear has priority over a simultaneous cal_done. That pulse is discarded and does not appear on the write side.
  - A clear in mid-frame discards every pulse still in flight in the delay line.
- Arithmetic: unsigned BIN_W bits. Wrap is explicit at NUM_BINS-1, not modulo 2^BIN_W, except where NUM_BINS == 2^BIN_W.

## Timing
- Reset value of every output is 0. rd_last is 0 after reset (it is 1 only if NUM_BINS-1 == 0, which is excluded).
- All outputs are registered except rd_last, which is a compare on registered bin_counts_rd with no input path.
- cal_done sampled at edge N → bin_counts_rd new value visible after edge N.
- The matching bin_counts update is visible after edge N+RD_LEAD.
- frame_done is high for the cycle following edge N+RD_LEAD, coincident with bin_counts showing 0 (wrap mode).
- Back-to-back cal_done every cycle is supported: throughput is 1 bin/cycle and the delay line holds up to RD_LEAD pulses.
- Between frames, bin_counts_rd leads bin_counts by exactly the number of accepted pulses in flight (≤ RD_LEAD).

## Structure
- Package rangebin_pkg holds:
  - default constants RB_BIN_W=5, RB_NUM_BINS=32, RB_RD_LEAD=3;
  - enum-style constants RB_MODE_WRAP=0, RB_MODE_SAT=1.
- Sub-module pulse_delay_line: parameter DEPTH; ports clk, rst, clr, din, dout. DEPTH flops, synchronous clear. Reused by other latency-matching blocks.
- The two counters are instances of the same inline counter logic. No further sub-modules.

## Test plan
- Defaults, 5 isolated cal_done pulses after rst → bin_counts_rd steps 0→5. Each bin_counts step trails its bin_counts_rd step by exactly 3 cycles; final bin_counts=5; overflow=0.
- Defaults, 32 back-to-back cal_done → bin_counts_rd sequence 1..31,0. rd_last is high during the cycle bin_counts_rd=31. frame_done pulses once, 3 cycles after the 32nd pulse's read update, with bin_counts=0.
- SATURATE=1, 35 pulses → bin_counts_rd holds at 31 and overflow is set from the 33rd pulse. bin_counts ends at 31. frame_done fires exactly once.
- Defaults, 10 pulses, then SPEC_Acc_Done 1 cycle after the 10th → both counters are 0 next cycle. No further bin_counts increments (in-flight pulses dropped). frame_done stays 0.
- cal_done and SPEC_Acc_Done in the same cycle with bin_counts_rd=7 → bin_counts_rd=0 and bin_counts reaches 0 and stays. No delayed increment 3 cycles later.
- BIN_W=4, NUM_BINS=12, RD_LEAD=1: 12 pulses → read index wraps 11→0. bin_counts wraps one cycle later, with frame_done coincident with that wrap. rst mid-stream zeroes all outputs on the next edge.

Source files
------------

// File: rtl/rangebin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rangebin_pkg
//  Description : Shared constants for the range-bin address generator:
//                default geometry and end-of-range mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package rangebin_pkg;

    // Default geometry: 32 bins addressed by 5 bits, write side 3 cycles behind
    localparam int RB_BIN_W     = 5;
    localparam int RB_NUM_BINS  = 32;
    localparam int RB_RD_LEAD   = 3;

    // End-of-range behaviour of the bin counters
    localparam int RB_MODE_WRAP = 0;
    localparam int RB_MODE_SAT  = 1;

endpackage : rangebin_pkg
`default_nettype wire

// File: rtl/pulse_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_delay_line
//  Description : DEPTH-stage single-bit shift register with synchronous
//                reset and clear. Used to align strobes with pipeline latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_sr;

    if (DEPTH == 1) begin : g_one
        // Single stage: the register is the whole delay
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                r_sr[0] <= 1'b0;
            end else begin
                r_sr[0] <= din;
            end
        end
    end else begin : g_multi
        // Shift towards the MSB; clear empties every stage at once
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                r_sr <= '0;
            end else begin
                r_sr <= {r_sr[DEPTH-2:0], din};
            end
        end
    end

    assign dout = r_sr[DEPTH-1];

endmodule : pulse_delay_line
`default_nettype wire

// File: rtl/rangebin_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rangebin_addr_gen
//  Description : Read/write range-bin address generator for the spectrum
//                accumulation RAM. The write index replays the accepted read
//                steps RD_LEAD cycles later. Flags frame completion and
//                overrun; cleared by the accumulation-done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module rangebin_addr_gen
    import rangebin_pkg::*;
#(
    parameter int BIN_W    = RB_BIN_W,
    parameter int NUM_BINS = RB_NUM_BINS,
    parameter int RD_LEAD  = RB_RD_LEAD,
    parameter int SATURATE = RB_MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cal_done,
    input  logic             SPEC_Acc_Done,
    output logic [BIN_W-1:0] bin_counts_rd,
    output logic [BIN_W-1:0] bin_counts,
    output logic             rd_last,
    output logic             frame_done,
    output logic             overflow
);

    localparam logic [BIN_W-1:0] c_LAST = BIN_W'(NUM_BINS - 1);

    // Index 0 is the read-side counter, index 1 the write-side counter
    logic                  w_clr;
    logic                  w_wr_acc;
    logic [1:0]            w_pulse;
    logic [1:0]            w_step;
    logic [1:0]            w_full;
    logic [1:0][BIN_W-1:0] w_idx;
    logic                  r_frame_done;
    logic                  r_overflow;

    assign w_clr      = SPEC_Acc_Done;
    assign w_pulse[0] = cal_done;
    assign w_pulse[1] = w_wr_acc;

    // Same counter logic for both sides; only the step source differs
    for (genvar k = 0; k < 2; k++) begin : g_ctr
        logic [BIN_W-1:0] r_idx;
        logic             w_at_last;

        assign w_at_last = (r_idx == c_LAST);

        if (SATURATE == RB_MODE_SAT) begin : g_sat
            logic r_full;

            // Latch "full" when the last bin is stepped; blocks further steps
            always_ff @(posedge clk) begin
                if (rst || w_clr) begin
                    r_full <= 1'b0;
                end else if (w_step[k] && w_at_last) begin
                    r_full <= 1'b1;
                end
            end

            assign w_full[k] = r_full;
        end else begin : g_wrap
            assign w_full[k] = 1'b0;
        end

        assign w_step[k] = w_pulse[k] & ~w_full[k];

        // Increment, then wrap to 0 or hold at the last bin
        always_ff @(posedge clk) begin
            if (rst || w_clr) begin
                r_idx <= '0;
            end else if (w_step[k]) begin
                if (w_at_last) begin
                    r_idx <= (SATURATE == RB_MODE_SAT) ? r_idx : '0;
                end else begin
                    r_idx <= r_idx + BIN_W'(1);
                end
            end
        end

        assign w_idx[k] = r_idx;
    end

    // Accepted read steps are replayed on the write side after RD_LEAD cycles
    pulse_delay_line #(
        .DEPTH (RD_LEAD)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .din  (w_step[0]),
        .dout (w_wr_acc)
    );

    // Frame completes when the write side steps off the last bin
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_step[1] && (w_idx[1] == c_LAST);
        end
    end

    // Sticky overrun: a pulse arrived while the read side was already full
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_overflow <= 1'b0;
        end else if (cal_done && w_full[0]) begin
            r_overflow <= 1'b1;
        end
    end

    assign bin_counts_rd = w_idx[0];
    assign bin_counts    = w_idx[1];
    assign rd_last       = (w_idx[0] == c_LAST);
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;

endmodule : rangebin_addr_gen
`default_nettype wire
